// File: rtl/spi_pkg.sv
// Shared frame layout and controller state encoding for the SPI register-write path.
// Imported by the initiator (spi_reg_writer) and by the peripheral register target.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[RW_BIT]            = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period down-counter: reloads on load, holds at zero, tick flags terminal count.
module spi_sclk_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI initiator that serializes {R/W, addr, data} register-write frames.
// Optional read support (req_write, cipo, rsp_valid, rsp_data) is built when SPI_READ_EN is defined.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// SETUP | ncs low, sclk low, copi = bit15, one half-period
// HIGH  | sclk high, one half-period (16 per frame)
// LOW   | sclk low, one half-period (16 per frame, last one precedes HOLD)
// HOLD  | ncs low, sclk low, copi keeps bit0, one half-period
// GAP   | ncs high for CS_GAP cycles, done pulses on entry
module spi_reg_writer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
`ifdef SPI_READ_EN
  input  logic              req_write,
  input  logic              cipo,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
`endif
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  output logic              done
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(CS_GAP - 1);

  spi_state_e          state, state_nx;
  logic [FRAME_W-2:0]  shreg;
  logic [3:0]          bit_cnt;
  logic                tick;
  logic                div_load;
  logic [7:0]          div_val;
  logic                accept;
  logic                rw_in;
  logic [FRAME_W-1:0]  frame_in;
  logic                shift_now;

`ifdef SPI_READ_EN
  assign rw_in = req_write;
`else
  assign rw_in = 1'b1;
`endif

  assign accept    = req_valid && req_ready;
  assign frame_in  = pack_frame(rw_in, req_addr, req_data);
  assign shift_now = (state == ST_HIGH) && tick && (bit_cnt != 4'd0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SETUP;
      ST_SETUP: if (tick)   state_nx = ST_HIGH;
      ST_HIGH:  if (tick)   state_nx = ST_LOW;
      ST_LOW:   if (tick)   state_nx = (bit_cnt == 4'd0) ? ST_HOLD : ST_HIGH;
      ST_HOLD:  if (tick)   state_nx = ST_GAP;
      ST_GAP:   if (tick)   state_nx = ST_IDLE;
      default:              state_nx = ST_IDLE;
    endcase
  end

  // Every state change reloads the half-period counter with the new state's length.
  assign div_load = (state_nx != state);
  assign div_val  = (state_nx == ST_GAP) ? GAP_LOAD : HALF_LOAD;

  spi_sclk_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .load_val (div_val),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= 4'd0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      sclk      <= (state_nx == ST_HIGH);
      ncs       <= (state_nx == ST_IDLE) || (state_nx == ST_GAP);
      done      <= (state_nx == ST_GAP) && (state != ST_GAP);
      req_ready <= (state_nx == ST_IDLE);

      // copi moves only at the HIGH->LOW edge, so it is stable at every sclk rise.
      if (accept) begin
        shreg   <= frame_in[FRAME_W-2:0];
        copi    <= frame_in[RW_BIT];
        bit_cnt <= 4'd15;
      end else if (shift_now) begin
        shreg   <= {shreg[FRAME_W-3:0], 1'b0};
        copi    <= shreg[FRAME_W-2];
      end

      if ((state == ST_LOW) && tick && (bit_cnt != 4'd0)) begin
        bit_cnt <= bit_cnt - 4'd1;
      end
    end
  end

`ifdef SPI_READ_EN
  logic [DATA_W-1:0] rx_shift;
  logic              is_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      is_read   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        is_read <= !req_write;
      end
      // Data-phase HIGH states are the last eight; sample at their final cycle.
      if ((state == ST_HIGH) && tick && (bit_cnt < 4'd8)) begin
        rx_shift <= {rx_shift[DATA_W-2:0], cipo};
      end
      if ((state == ST_HOLD) && tick && is_read) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rx_shift;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: two lanes (CLK_DIV=4 and CLK_DIV=7), each with a
// peripheral model that captures frames off the wire and compares them to queued expectations.
`timescale 1ns/1ps
module tb_spi_reg_writer;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic               is_read;
    logic [7:0]         rsp;
  } exp_t;

  task automatic check(input int ln, input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h (t=%0t)", ln, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D         = (g == 0) ? 4 : 7;
    localparam int G         = 4;
    localparam int LOW_LEN   = 34 * D;
    localparam int READY_LAT = 1 + 34 * D + G;

    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sclk, ncs, copi, done;
`ifdef SPI_READ_EN
    logic       req_write;
    logic       cipo;
    logic       rsp_valid;
    logic [7:0] rsp_data;
`endif

    exp_t       sb[$];
    bit         finished = 1'b0;
    logic [7:0] periph_regs [128];
    logic [7:0] model_regs  [128];

    spi_reg_writer #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
`ifdef SPI_READ_EN
      .req_write (req_write),
      .cipo      (cipo),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
`endif
      .sclk      (sclk),
      .ncs       (ncs),
      .copi      (copi),
      .done      (done)
    );

    // Peripheral model and monitor: sample on the falling clk edge.
    initial begin
      logic               p_sclk, p_ncs, p_copi;
      logic               ncs_fall, ncs_rise, sclk_rise, sclk_fall;
      int                 low_cnt, phase_cnt, rises, falls, gap_cnt;
      bit                 seen_frame;
      logic [FRAME_W-1:0] cap;
      exp_t               e;
`ifdef SPI_READ_EN
      logic [7:0]         resp_byte;
      resp_byte = 8'h00;
      cipo      = 1'b0;
`endif
      for (int i = 0; i < 128; i++) periph_regs[i] = 8'h00;
      p_sclk = 1'b0; p_ncs = 1'b1; p_copi = 1'b0;
      low_cnt = 0; phase_cnt = 0; rises = 0; falls = 0; gap_cnt = 0;
      seen_frame = 1'b0; cap = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          p_sclk = sclk; p_ncs = ncs; p_copi = copi;
          seen_frame = 1'b0;
          continue;
        end
        ncs_fall  = p_ncs && !ncs;
        ncs_rise  = !p_ncs && ncs;
        sclk_rise = !p_sclk && sclk;
        sclk_fall = p_sclk && !sclk;
        if (ncs_fall) begin
          if (seen_frame) check(g, "cs_gap_min", longint'(gap_cnt >= G), 1);
          low_cnt = 1; phase_cnt = 1; rises = 0; falls = 0; cap = '0;
        end else if (!ncs) begin
          low_cnt++;
          if (sclk_rise) begin
            check(g, "copi_stable_at_rise", copi, p_copi);
            check(g, "low_phase_len", phase_cnt, D);
            cap = {cap[FRAME_W-2:0], copi};
            rises++;
            phase_cnt = 1;
          end else if (sclk_fall) begin
            check(g, "high_phase_len", phase_cnt, D);
            falls++;
            phase_cnt = 1;
`ifdef SPI_READ_EN
            if (falls == 8) resp_byte = periph_regs[cap[6:0]];
            if (falls >= 8 && falls <= 15) cipo = resp_byte[15 - falls];
`endif
          end else begin
            phase_cnt++;
            check(g, "copi_changes_only_on_fall", copi, p_copi);
          end
        end
        if (ncs_rise) begin
          check(g, "done_at_ncs_rise", done, 1);
          check(g, "ncs_low_len", low_cnt, LOW_LEN);
          check(g, "last_low_plus_hold_len", phase_cnt, 2 * D);
          check(g, "sclk_rise_count", rises, 16);
          check(g, "frame_was_expected", longint'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check(g, "frame_bits", cap, e.frame);
            if (cap[RW_BIT]) periph_regs[cap[ADDR_MSB:ADDR_LSB]] = cap[DATA_MSB:DATA_LSB];
`ifdef SPI_READ_EN
            check(g, "rsp_valid_with_done", rsp_valid, e.is_read);
            if (e.is_read) check(g, "rsp_data", rsp_data, e.rsp);
`endif
          end
          gap_cnt = 1;
          seen_frame = 1'b1;
        end else if (ncs) begin
          gap_cnt++;
        end
        if (done && !ncs_rise) check(g, "done_only_at_ncs_rise", ncs_rise, 1);
`ifdef SPI_READ_EN
        if (rsp_valid && !ncs_rise) check(g, "rsp_valid_only_at_ncs_rise", ncs_rise, 1);
`endif
        p_sclk = sclk; p_ncs = ncs; p_copi = copi;
      end
    end

    // Issue one request from a negedge; returns on the negedge where req_ready is back.
    task automatic send(input logic [6:0] a, input logic [7:0] d, input logic wr, input bit keep_valid);
      int   n;
      exp_t e;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
`ifdef SPI_READ_EN
      req_write = wr;
`endif
      n = 0;
      while (!req_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check(g, "accept_within_bound", longint'(n < 3000), 1);
      if (n >= 3000) begin
        req_valid = 1'b0;
        return;
      end
      e.frame   = {wr, a, d};
      e.is_read = !wr;
      e.rsp     = model_regs[a];
      if (wr) model_regs[a] = d;
      sb.push_back(e);
      @(negedge clk);
      check(g, "ncs_low_in_cycle1", ncs, 0);
      check(g, "ready_low_after_accept", req_ready, 0);
      if (!keep_valid) req_valid = 1'b0;
      req_addr = 7'($urandom);
      req_data = 8'($urandom);
      n = 1;
      while (!req_ready && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check(g, "ready_return_cycle", n, READY_LAT);
    endtask

    initial begin
      bit         bad;
      bit         keep;
      logic [6:0] a;
      logic [7:0] d;
      logic       wr;
      for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
`ifdef SPI_READ_EN
      req_write = 1'b1;
`endif
      @(negedge clk);
      check(g, "reset_ncs", ncs, 1);
      check(g, "reset_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      bad = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (sclk !== 1'b0 || ncs !== 1'b1 || copi !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0)
          bad = 1'b1;
      end
      check(g, "idle_outputs_100_cycles", bad, 0);

      send(7'h02, 8'hA5, 1'b1, 1'b0);
      repeat (3) @(negedge clk);

      // Two queued requests with req_valid held across the first frame.
      send(7'h00, 8'h11, 1'b1, 1'b1);
      send(7'h04, 8'hFF, 1'b1, 1'b0);
      check(g, "periph_reg0", periph_regs[0], 8'h11);
      check(g, "periph_reg4", periph_regs[4], 8'hFF);
      repeat (2) @(negedge clk);

      // Reset during the HIGH phase of bit 9 (addr bit 1 forced high so copi is 1 there).
      req_valid = 1'b1;
      req_addr  = 7'($urandom) | 7'h02;
      req_data  = 8'($urandom);
`ifdef SPI_READ_EN
      req_write = 1'b1;
`endif
      @(negedge clk);
      req_valid = 1'b0;
      repeat (13 * D) @(negedge clk);
      check(g, "abort_point_sclk_high", sclk, 1);
      check(g, "abort_point_copi_bit9", copi, 1);
      rst_n = 1'b0;
      #1;
      check(g, "abort_ncs", ncs, 1);
      check(g, "abort_sclk", sclk, 0);
      check(g, "abort_copi", copi, 0);
      check(g, "abort_done", done, 0);
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(7'h55, 8'h3A, 1'b1, 1'b0);

`ifdef SPI_READ_EN
      send(7'h03, 8'h3C, 1'b1, 1'b0);
      send(7'h03, 8'h00, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check(g, "rsp_data_holds", rsp_data, 8'h3C);
`endif

      for (int k = 0; k < 6; k++) begin
        a    = 7'($urandom);
        d    = 8'($urandom);
        keep = 1'($urandom_range(0, 1));
`ifdef SPI_READ_EN
        wr   = 1'($urandom_range(0, 1));
`else
        wr   = 1'b1;
`endif
        send(a, d, wr, keep);
        if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check(g, "scoreboard_drained", sb.size(), 0);
      finished = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].finished && lane[1].finished) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check(-1, "all_lanes_finished", longint'(lane[0].finished && lane[1].finished), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
